// File: rtl/espsid_clk_pkg.sv
// Shared definitions for the SID phi2 clock NCO.
//   ACC_W_DEF : default phase-accumulator width
//   MODE_*    : encodings of the mode_sel input
//   calc_inc  : elaboration-time increment calculation with round-to-nearest
package espsid_clk_pkg;

    localparam int unsigned ACC_W_DEF = 32'd24;

    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_CUST = 2'b10;
    localparam logic [1:0] MODE_STOP = 2'b11;

    // The accumulator wraps twice per output period (one wrap per half-period),
    // hence the factor of two. Adding sys_clk/2 before dividing rounds to nearest.
    function automatic longint unsigned calc_inc(
        input longint unsigned sys_clk,
        input longint unsigned f_out,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (64'd2 * f_out) << acc_w;
        return (num + (sys_clk >> 1)) / sys_clk;
    endfunction

endpackage

// File: rtl/sid_nco_core.sv
// Phase accumulator core of the SID clock NCO.
// Adds active_inc_i to the accumulator on every enabled cycle; every carry out
// of the accumulator toggles sid_clk_o. The matching strobe is registered on
// the same edge as the new level, so strobe and level appear together.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-low reset
//   en_i       : 1 = accumulate, 0 = hold accumulator and level
//   active_inc_i : increment in use (0 = stopped)
//   sid_clk_o  : registered SID phi2 clock
//   rise_stb_o : one-cycle pulse with sid_clk_o becoming 1
//   fall_stb_o : one-cycle pulse with sid_clk_o becoming 0
//   carry_o    : combinational, a toggle is being registered this cycle
module sid_nco_core
    import espsid_clk_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [ACC_W-1:0] active_inc_i,
    output logic             sid_clk_o,
    output logic             rise_stb_o,
    output logic             fall_stb_o,
    output logic             carry_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             sid_q;
    logic             sid_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [ACC_W:0]   sum_s;
    logic             step_s;

    // Next-state logic: accumulate, detect carry, toggle level and raise strobe.
    always_comb begin
        step_s  = en_i && (active_inc_i != {ACC_W{1'b0}});
        sum_s   = {1'b0, acc_q} + {1'b0, active_inc_i};
        carry_o = 1'b0;
        acc_d   = acc_q;
        sid_d   = sid_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (step_s) begin
            acc_d = sum_s[ACC_W-1:0];
            if (sum_s[ACC_W]) begin
                // Increment is below half the range, so at most one carry per cycle.
                carry_o = 1'b1;
                sid_d   = ~sid_q;
                rise_d  = ~sid_q;
                fall_d  = sid_q;
            end else begin
                carry_o = 1'b0;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State register for accumulator, clock level and strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= {ACC_W{1'b0}};
            sid_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            sid_q  <= sid_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sid_clk_o  = sid_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;

endmodule

// File: rtl/sid_clk_nco.sv
// SID phi2 clock generator using a phase-accumulator NCO.
// Selects between two preset increments, a host-programmable increment and
// stop; rate changes take effect only on a rising sid_clk boundary so the
// output never glitches.
// Optional feature macro: SID_CYCLE_COUNT_EN adds cycle_cnt, a 32-bit count of
// rising edges for host-side timestamping.
// Ports:
//   clk, rst      : system clock, synchronous active-low reset
//   en            : 1 = run, 0 = freeze accumulator and sid_clk
//   mode_sel      : 00 preset A, 01 preset B, 10 custom, 11 stop
//   inc_wr/inc_data : custom increment write strobe and value
//   inc_err       : one-cycle pulse after a rejected write
//   upd_pending   : selected increment differs from active increment
//   sid_clk       : SID phi2 clock
//   rise_stb/fall_stb : single-cycle edge strobes aligned with sid_clk
//   cycle_cnt     : rising-edge count (SID_CYCLE_COUNT_EN only)
module sid_clk_nco
    import espsid_clk_pkg::*;
#(
    parameter int unsigned SYS_CLK     = 32'd20000000,
    parameter int unsigned CLK_OUT     = 32'd1000000,
    parameter int unsigned ALT_CLK_OUT = 32'd985248,
    parameter int unsigned ACC_W       = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode_sel,
    input  logic             inc_wr,
    input  logic [ACC_W-1:0] inc_data,
    output logic             inc_err,
    output logic             upd_pending,
    output logic             sid_clk,
    output logic             rise_stb,
    output logic             fall_stb
`ifdef SID_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_cnt
`endif
);

    localparam longint unsigned INC_A_L  = calc_inc(64'(SYS_CLK), 64'(CLK_OUT), ACC_W);
    localparam longint unsigned INC_B_L  = calc_inc(64'(SYS_CLK), 64'(ALT_CLK_OUT), ACC_W);
    localparam longint unsigned INC_LIM  = 64'd1 << (ACC_W - 32'd1);
    localparam logic [ACC_W-1:0] INC_A   = INC_A_L[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_B   = INC_B_L[ACC_W-1:0];

    // An increment of half the range or more would allow two toggles per cycle.
    if (INC_A_L == 64'd0 || INC_A_L >= INC_LIM) begin : g_bad_inc_a
        $error("sid_clk_nco: CLK_OUT gives an increment outside 1..2^(ACC_W-1)-1");
    end
    if (INC_B_L == 64'd0 || INC_B_L >= INC_LIM) begin : g_bad_inc_b
        $error("sid_clk_nco: ALT_CLK_OUT gives an increment outside 1..2^(ACC_W-1)-1");
    end

    logic [ACC_W-1:0] active_inc_q;
    logic [ACC_W-1:0] active_inc_d;
    logic [ACC_W-1:0] custom_inc_q;
    logic [ACC_W-1:0] custom_inc_d;
    logic             inc_err_q;
    logic             inc_err_d;
    logic [ACC_W-1:0] sel_inc_s;
    logic             wr_ok_s;
    logic             carry_s;
    logic             sid_clk_s;
    logic             boundary_s;

    sid_nco_core #(
        .ACC_W        (ACC_W)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .active_inc_i (active_inc_q),
        .sid_clk_o    (sid_clk_s),
        .rise_stb_o   (rise_stb),
        .fall_stb_o   (fall_stb),
        .carry_o      (carry_s)
    );

    // Increment selected by mode_sel; stop maps to zero.
    always_comb begin
        sel_inc_s = INC_A;
        case (mode_sel)
            MODE_A:    sel_inc_s = INC_A;
            MODE_B:    sel_inc_s = INC_B;
            MODE_CUST: sel_inc_s = custom_inc_q;
            MODE_STOP: sel_inc_s = {ACC_W{1'b0}};
            default:   sel_inc_s = {ACC_W{1'b0}};
        endcase
    end

    // Custom write validation and rate-change boundary handling.
    always_comb begin
        // A rising toggle is the only safe point to swap increments.
        boundary_s   = carry_s & ~sid_clk_s;
        wr_ok_s      = (inc_data != {ACC_W{1'b0}}) && (inc_data[ACC_W-1] == 1'b0);
        custom_inc_d = custom_inc_q;
        inc_err_d    = 1'b0;
        active_inc_d = active_inc_q;
        if (inc_wr) begin
            if (wr_ok_s) begin
                custom_inc_d = inc_data;
            end else begin
                inc_err_d = 1'b1;
            end
        end else begin
            inc_err_d = 1'b0;
        end
        // sel_inc_s uses the pre-write custom_inc_q, so a write that coincides
        // with a boundary stays pending until the next one.
        if (en && (active_inc_q == {ACC_W{1'b0}})) begin
            // Stopped: no carry can ever occur, so restart immediately.
            active_inc_d = sel_inc_s;
        end else if (boundary_s) begin
            active_inc_d = sel_inc_s;
        end else begin
            active_inc_d = active_inc_q;
        end
    end

    // Increment and error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_inc_q <= INC_A;
            custom_inc_q <= INC_A;
            inc_err_q    <= 1'b0;
        end else begin
            active_inc_q <= active_inc_d;
            custom_inc_q <= custom_inc_d;
            inc_err_q    <= inc_err_d;
        end
    end

    // Pending flag compares registered state against the current selection.
    always_comb begin
        upd_pending = (sel_inc_s != active_inc_q);
    end

    assign inc_err = inc_err_q;
    assign sid_clk = sid_clk_s;

`ifdef SID_CYCLE_COUNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Counter advances on the edge that raises rise_stb, so both update together.
    always_comb begin
        if (boundary_s) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Rising-edge counter register; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sid_clk_nco.sv
// Self-checking bench for sid_clk_nco with default parameters.
// A phase model (unbounded phase counter; sid_clk is bit ACC_W of the phase)
// is checked against the DUT every cycle, alongside directed measurements of
// edge timing with hand-computed expectations.
module tb_sid_clk_nco;

    localparam int ACC_W = 24;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode_sel;
    logic             inc_wr;
    logic [ACC_W-1:0] inc_data;
    logic             inc_err;
    logic             upd_pending;
    logic             sid_clk;
    logic             rise_stb;
    logic             fall_stb;
`ifdef SID_CYCLE_COUNT_EN
    logic [31:0]      cycle_cnt;
`endif

    sid_clk_nco dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode_sel    (mode_sel),
        .inc_wr      (inc_wr),
        .inc_data    (inc_data),
        .inc_err     (inc_err),
        .upd_pending (upd_pending),
        .sid_clk     (sid_clk),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb)
`ifdef SID_CYCLE_COUNT_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int     m_inca;
    int     m_incb;
    longint ph;
    int     m_act;
    int     m_cust;
    int     m_sel;
    bit     m_rise;
    bit     m_fall;
    bit     m_err;
    bit     m_ok;
    bit     b_old;
    int     m_cnt;

    function automatic int sel_of(input logic [1:0] m, input int c);
        case (m)
            2'd0:    return m_inca;
            2'd1:    return m_incb;
            2'd2:    return c;
            default: return 0;
        endcase
    endfunction

    initial begin
        m_inca = $rtoi(2.0 * 1.0e6 * 16777216.0 / 2.0e7 + 0.5);
        m_incb = $rtoi(2.0 * 985248.0 * 16777216.0 / 2.0e7 + 0.5);
        ph = 0; m_act = m_inca; m_cust = m_inca; m_cnt = 0;
        m_rise = 1'b0; m_fall = 1'b0; m_err = 1'b0;
    end

    // Model advance on each active edge from the inputs held across it.
    always @(posedge clk) begin
        if (!rst) begin
            ph = 0; m_act = m_inca; m_cust = m_inca;
            m_rise = 1'b0; m_fall = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            m_sel  = sel_of(mode_sel, m_cust);
            m_ok   = (int'(inc_data) > 0) && (int'(inc_data) < (1 << (ACC_W - 1)));
            m_err  = inc_wr && !m_ok;
            if (inc_wr && m_ok) m_cust = int'(inc_data);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (en) begin
                if (m_act == 0) m_act = m_sel;
                else begin
                    b_old = ph[ACC_W];
                    ph = ph + longint'(m_act);
                    if (ph[ACC_W] != b_old) begin
                        if (ph[ACC_W]) begin
                            m_rise = 1'b1;
                            m_act  = m_sel;
                            m_cnt++;
                        end else m_fall = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("sid_clk",     {31'd0, sid_clk},     {31'd0, ph[ACC_W]});
            chk("rise_stb",    {31'd0, rise_stb},    {31'd0, m_rise});
            chk("fall_stb",    {31'd0, fall_stb},    {31'd0, m_fall});
            chk("inc_err",     {31'd0, inc_err},     {31'd0, m_err});
            chk("upd_pending", {31'd0, upd_pending}, {31'd0, (sel_of(mode_sel, m_cust) != m_act)});
`ifdef SID_CYCLE_COUNT_EN
            chk("cycle_cnt", cycle_cnt, m_cnt);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    // Counts active edges until a strobe is seen (sampled 2 time units after the edge).
    task automatic wait_strobe(output int n, output bit was_rise);
        n = 0;
        was_rise = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            n++;
            if (rise_stb || fall_stb) begin
                was_rise = rise_stb;
                return;
            end
        end
        chk("strobe_timeout", 32'd0, 32'd1);
        n = -1;
    endtask

    task automatic wait_rise(output int n);
        bit r;
        int k;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(k, r);
            n += k;
            if (r) return;
        end
        chk("rise_not_found", 32'd0, 32'd1);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int n;
    int n2;
    bit r;
    int cnt;

    initial begin
        rst = 1'b0; en = 1'b0; mode_sel = 2'd0; inc_wr = 1'b0; inc_data = '0;
        chk("model_inc_a", m_inca, 32'h0019999A);
        chk("model_inc_b", m_incb, 32'd1652972);

        // Reset state
        cyc(3);
        chk_on = 1'b1;
        chk("rst_sid_clk", {31'd0, sid_clk}, 32'd0);
        chk("rst_rise",    {31'd0, rise_stb}, 32'd0);
        chk("rst_fall",    {31'd0, fall_stb}, 32'd0);
        chk("rst_err",     {31'd0, inc_err}, 32'd0);
        chk("rst_upd",     {31'd0, upd_pending}, 32'd0);

        // Mode 00: first rise on enabled cycle 10, then 10 high / 10 low
        rst = 1'b1; en = 1'b1;
        wait_strobe(n, r);
        chk("first_rise_cycle", n, 32'd10);
        chk("first_is_rise", {31'd0, r}, 32'd1);
        for (int p = 0; p < 2; p++) begin
            wait_strobe(n, r);
            chk("a_high_time", n, 32'd10);
            wait_strobe(n2, r);
            chk("a_period", n + n2, 32'd20);
        end

        // Switch to preset B four cycles into the high phase
        cyc(4);
        mode_sel = 2'd1;
        #1;
        chk("upd_after_switch", {31'd0, upd_pending}, 32'd1);
        wait_strobe(n, r);
        chk("switch_high_range", {31'd0, (n + 4 >= 10 && n + 4 <= 11)}, 32'd1);
        chk("upd_before_rise", {31'd0, upd_pending}, 32'd1);
        wait_strobe(n, r);
        chk("switch_low_range", {31'd0, (n >= 10 && n <= 11)}, 32'd1);
        chk("upd_after_rise", {31'd0, upd_pending}, 32'd0);
        for (int h = 0; h < 30; h++) begin
            wait_strobe(n, r);
            chk("b_half_range", {31'd0, (n >= 10 && n <= 11)}, 32'd1);
        end

        // Preset B long-run rate: 20000 * 1652972 / 2^25 = 985.25 rises
        cnt = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            #2;
            if (rise_stb) cnt++;
        end
        chk("b_rise_count_in_range", {31'd0, (cnt >= 984 && cnt <= 987)}, 32'd1);

        // Custom writes: zero and 0x800000 rejected, 0x19999A accepted
        inc_wr = 1'b1; inc_data = 24'h000000;
        cyc(1);
        inc_wr = 1'b0;
        chk("err_zero", {31'd0, inc_err}, 32'd1);
        cyc(1);
        chk("err_pulse_len", {31'd0, inc_err}, 32'd0);
        inc_wr = 1'b1; inc_data = 24'h800000;
        cyc(1);
        inc_wr = 1'b0;
        chk("err_half", {31'd0, inc_err}, 32'd1);
        inc_wr = 1'b1; inc_data = 24'h19999A;
        cyc(1);
        inc_wr = 1'b0;
        chk("err_good", {31'd0, inc_err}, 32'd0);
        mode_sel = 2'd2;
        #1;
        chk("upd_custom", {31'd0, upd_pending}, 32'd1);
        wait_rise(n);
        wait_strobe(n, r);
        wait_strobe(n2, r);
        chk("custom_period", n + n2, 32'd20);
        chk("custom_ends_rise", {31'd0, r}, 32'd1);

        // Stop: holds high after next rise, no strobes for 100 cycles
        mode_sel = 2'd3;
        wait_rise(n);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (rise_stb || fall_stb || !sid_clk) cnt++;
        end
        chk("stop_quiet_high", cnt, 32'd0);
        // Restart: one load cycle plus at most ten accumulate cycles to the fall
        mode_sel = 2'd0;
        wait_strobe(n, r);
        chk("restart_bound", {31'd0, (n >= 1 && n <= 11)}, 32'd1);
        chk("restart_is_fall", {31'd0, r}, 32'd0);

        // Fresh reset, then freeze 7 cycles inside the high phase
        rst = 1'b0;
        cyc(1);
        chk("rst2_sid_clk", {31'd0, sid_clk}, 32'd0);
        chk("rst2_upd", {31'd0, upd_pending}, 32'd0);
        rst = 1'b1;
        wait_strobe(n, r);
        chk("rst2_first_rise", n, 32'd10);
        cyc(3);
        en = 1'b0;
        cyc(7);
        en = 1'b1;
        wait_strobe(n, r);
        chk("stretched_high", n + 10, 32'd17);
        wait_strobe(n, r);
        chk("after_stretch_low", n, 32'd10);

        // Reset in the middle of the high phase
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst3_sid_clk", {31'd0, sid_clk}, 32'd0);
        chk("rst3_upd", {31'd0, upd_pending}, 32'd0);
`ifdef SID_CYCLE_COUNT_EN
        chk("rst3_cycle_cnt", cycle_cnt, 32'd0);
`endif
        rst = 1'b1;
        wait_strobe(n, r);
        chk("rst3_first_rise", n, 32'd10);
`ifdef SID_CYCLE_COUNT_EN
        chk("cnt_first_rise", cycle_cnt, 32'd1);
`endif
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sid_clk_nco.md
Name: sid_clk_nco

Overview:
- Parametrised successor to the fixed integer SID clock divider.
- Produces the SID phi2 clock (sid_clk) from the CPLD system clock using a phase-accumulator NCO, so non-integer ratios (PAL 985248 Hz, NTSC 1022727 Hz) are exact on average.
- Run-time source select: two presets, a host-programmable increment, or stop.
- Single-cycle rise/fall strobes for the bus-interface logic; rate changes are glitch-free, applied only on a sid_clk rising-edge boundary.

Parameters:
- SYS_CLK, 20000000, system clock frequency in Hz.
- CLK_OUT, 1000000, preset A output frequency in Hz (mode 00).
- ALT_CLK_OUT, 985248, preset B output frequency in Hz (mode 01).
- ACC_W, 24, accumulator width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- en  in  1  1 = accumulate; 0 = freeze accumulator and sid_clk level
- mode_sel  in  2  00 preset A, 01 preset B, 10 custom register, 11 stop
- inc_wr  in  1  one-cycle write strobe for the custom increment
- inc_data  in  ACC_W  custom increment value
- inc_err  out  1  one-cycle pulse: rejected write
- upd_pending  out  1  selected increment differs from the active increment
- sid_clk  out  1  SID phi2 clock
- rise_stb  out  1  high in the cycle sid_clk becomes 1
- fall_stb  out  1  high in the cycle sid_clk becomes 0

Behaviour:
- Increment constants: INC_A = round(2*CLK_OUT*2^ACC_W/SYS_CLK), INC_B likewise from ALT_CLK_OUT, computed at elaboration.
  - Elaboration error if either is 0 or >= 2^(ACC_W-1), i.e. output above SYS_CLK/4.
- Reset (rst==0 at a clk edge):
  - acc=0, sid_clk=0, rise_stb=0, fall_stb=0, inc_err=0.
  - active_inc=INC_A, custom_inc=INC_A.
- Each cycle with en=1 and active_inc!=0: sum = acc + active_inc, computed ACC_W+1 bits wide; acc <= sum[ACC_W-1:0]; carry = sum[ACC_W].
- On carry: sid_clk toggles, registered. rise_stb or fall_stb is registered in the same cycle, so strobe and new level appear together.
- Strobes are otherwise 0. At most one toggle per cycle, guaranteed by the increment bound.
- en=0: acc, sid_clk and active_inc hold; strobes and inc_err still update (strobes 0).
- Selected increment: mode 00 -> INC_A, 01 -> INC_B, 10 -> custom_inc, 11 -> 0.
- Rate-change boundary: active_inc <= selected increment only in a cycle where carry occurs and sid_clk is currently 0 (rising toggle). The new value is used from the next cycle; acc is not cleared.
- Starting from stop (active_inc==0): the next en=1 cycle loads the selected increment immediately; acc keeps its residue.
- Mode 11 therefore stops after the next rising edge, with sid_clk held high until restarted.
- upd_pending = (selected increment != active_inc); combinational compare of registered values.
- Custom write: on inc_wr with 0 < inc_data < 2^(ACC_W-1), custom_inc <= inc_data. Otherwise custom_inc is unchanged and inc_err pulses in the next cycle.
- inc_wr in the same cycle as a boundary: active_inc takes the old custom_inc; the new value pends.
- Latency:
  - First rise occurs on enabled cycle ceil(2^ACC_W/INC_A) after reset; 10 cycles with defaults.
  - Steady-state default period is 20 cycles, high time 10.
- Non-integer ratios: half-periods differ by at most one clk cycle; long-term average frequency is within 1 ppm-of-quantisation of target.

Optional Feature:
- Macro SID_CYCLE_COUNT_EN.
- Defined: adds output cycle_cnt [31:0], reset to 0, incremented on every rise_stb, wraps 0xFFFFFFFF -> 0. Used by the host for SID register-write timestamping.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package espsid_clk_pkg:
  - ACC_W default.
  - mode_sel localparams MODE_A, MODE_B, MODE_CUST, MODE_STOP.
  - Constant function calc_inc(sys_clk, f_out, acc_w) with rounding.
- One sub-module, sid_nco_core: accumulator, carry, sid_clk toggle and strobes, given active_inc and en.
- Top level holds mode mux, custom register, validation, boundary update and the optional counter.

Test Plan:
- Reset with defaults, en=1, mode 00: first rise_stb on cycle 10, then sid_clk period 20, high 10; all outputs 0 during reset.
- Mode 01 defaults: in 1,000,000 enabled cycles, rise count 49262 +/-1; every half-period is 10 or 11 cycles.
- Mode switch 00->01 mid-high-phase: upd_pending=1 until next rise; no half-period outside 10..11 cycles; upd_pending=0 after.
- inc_wr with 0, then 0x800000, then 0x19999A:
  - First two: inc_err pulse, custom_inc unchanged.
  - Third: accepted; in mode 10, period 20 after next rise.
- Mode 11 while running: stops high after next rise, no strobes for 100 cycles; return to mode 00 restarts within 10 cycles.
- en=0 for 7 cycles mid-period, then rst=0 mid-high: period stretched by exactly 7 cycles; after reset, sid_clk=0, active_inc=INC_A. With SID_CYCLE_COUNT_EN, cycle_cnt=0 after reset and increments per rise.
